// File: rtl/flow_buf_fifo_if.sv
// Handshake bundle for flow_buf_fifo: upstream push side, downstream pop side
// and occupancy status.
interface flow_buf_fifo_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             Valid_i;
   logic [WIDTH-1:0] Data_i;
   logic             Ready_o;
   logic             Valid_o;
   logic [WIDTH-1:0] Data_o;
   logic             Ready_i;
   logic [CNT_W-1:0] Count_o;
   logic             Full_o;
   logic             Empty_o;

   modport slave (
      input  Valid_i, Data_i, Ready_i,
      output Ready_o, Valid_o, Data_o, Count_o, Full_o, Empty_o
   );

   modport master (
      output Valid_i, Data_i, Ready_i,
      input  Ready_o, Valid_o, Data_o, Count_o, Full_o, Empty_o
   );
endinterface

// File: rtl/flow_buf_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides. Handshake
// outputs come only from registered state, so there is no Valid_i/Ready_i bypass.
module flow_buf_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   flow_buf_fifo_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_PARTIAL,
      S_FULL
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic push;
   logic pop;
   logic wr_en;

   assign bus.Ready_o = (state_q != S_FULL);
   assign bus.Valid_o = (state_q != S_EMPTY);
   assign bus.Full_o  = (state_q == S_FULL);
   assign bus.Empty_o = (state_q == S_EMPTY);
   assign bus.Count_o = count_q;
   assign bus.Data_o  = mem_q[rd_ptr_q];

   always_comb begin
      push     = bus.Valid_i && (state_q != S_FULL);
      pop      = bus.Ready_i && (state_q != S_EMPTY);
      // Storage is not reset, so block writes explicitly while reset is held.
      wr_en    = push && !RESET;
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);

      unique case (state_q)
         S_EMPTY: begin
            if (push) state_d = S_PARTIAL;
         end
         S_PARTIAL: begin
            if (push && !pop && (count_q == CNT_W'(DEPTH - 1)))
               state_d = S_FULL;
            else if (pop && !push && (count_q == CNT_W'(1)))
               state_d = S_EMPTY;
         end
         S_FULL: begin
            if (pop) state_d = S_PARTIAL;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_EMPTY;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= bus.Data_i;
   end
endmodule
